// File: rtl/ctrl_gen.sv
// Control-bus master driver: one start pulse, len valid beats paced by en, one stop pulse.
// Exports the running beat index so the consuming stage needs no counter of its own.
module ctrl_gen #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [WIDTH-1:0] len,
  input  logic             en,
  output logic             busy,
  output logic             start,
  output logic             valid,
  output logic             stop,
  output logic [WIDTH-1:0] index
);

  // state | meaning
  // IDLE  | no sequence open; req accepted here
  // START | start pulse showing; en at this edge decides the first beat
  // RUN   | beats being emitted as en allows; remain==0 closes the sequence
  // STOP  | stop pulse showing; returns to IDLE
  typedef enum logic [1:0] {IDLE, START, RUN, STOP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] remain, remain_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic [WIDTH-1:0] index_nxt;
  logic             start_nxt, valid_nxt, stop_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      remain <= '0;
      count  <= '0;
      start  <= 1'b0;
      valid  <= 1'b0;
      stop   <= 1'b0;
      index  <= '0;
    end else begin
      state  <= state_nxt;
      remain <= remain_nxt;
      count  <= count_nxt;
      start  <= start_nxt;
      valid  <= valid_nxt;
      stop   <= stop_nxt;
      index  <= index_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    remain_nxt = remain;
    count_nxt  = count;
    index_nxt  = index;
    start_nxt  = 1'b0;
    valid_nxt  = 1'b0;
    stop_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt  = START;
          remain_nxt = len;
          count_nxt  = '0;
          index_nxt  = '0;
          start_nxt  = 1'b1;
        end
      end
      START, RUN: begin
        if (remain == '0) begin
          state_nxt = STOP;
          stop_nxt  = 1'b1;
        end else begin
          state_nxt = RUN;
          // index shows the beat number while valid is high and holds across stalls
          if (en) begin
            valid_nxt  = 1'b1;
            index_nxt  = count;
            count_nxt  = count + WIDTH'(1);
            remain_nxt = remain - WIDTH'(1);
          end
        end
      end
      STOP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ctrl_gen.sv
// Bench for ctrl_gen: directed sequences with literal timelines, then random traffic
// checked every cycle against a beat-level reference model.
module tb_ctrl_gen;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req = 1'b0;
  logic [W-1:0] len = '0;
  logic         en  = 1'b0;
  logic         busy, start, valid, stop;
  logic [W-1:0] index;

  logic         req4 = 1'b0;
  logic [3:0]   len4 = '0;
  logic         busy4, start4, valid4, stop4;
  logic [3:0]   index4;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  ctrl_gen #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .req(req), .len(len), .en(en),
    .busy(busy), .start(start), .valid(valid), .stop(stop), .index(index)
  );

  ctrl_gen #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req4), .len(len4), .en(en),
    .busy(busy4), .start(start4), .valid(valid4), .stop(stop4), .index(index4)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: tracks an open sequence as beats left / beats done.
  bit           m_open = 1'b0;
  int           m_left = 0;
  int           m_done = 0;
  logic         e_busy = 1'b0, e_start = 1'b0, e_valid = 1'b0, e_stop = 1'b0;
  logic [W-1:0] e_index = '0;
  bit           e_idx_known = 1'b0;

  always @(posedge clk) begin
    e_idx_known = 1'b0;
    if (rst) begin
      m_open = 1'b0;
      {e_busy, e_start, e_valid, e_stop} = 4'b0;
      e_index = '0;
      e_idx_known = 1'b1;
    end else if (!m_open) begin
      e_valid = 1'b0;
      e_stop  = 1'b0;
      if (req) begin
        m_open  = 1'b1;
        m_left  = int'(len);
        m_done  = 0;
        e_start = 1'b1;
        e_busy  = 1'b1;
      end else begin
        e_start = 1'b0;
        e_busy  = 1'b0;
      end
    end else if (e_stop) begin
      m_open = 1'b0;
      {e_busy, e_start, e_valid, e_stop} = 4'b0;
    end else if (m_left == 0) begin
      e_start = 1'b0;
      e_valid = 1'b0;
      e_stop  = 1'b1;
    end else begin
      e_start = 1'b0;
      e_valid = en;
      if (en) begin
        e_index = W'(m_done);
        e_idx_known = 1'b1;
        m_done++;
        m_left--;
      end
    end
    #1;
    if (chk_on) begin
      chk("model_ctrl", {28'b0, busy, start, valid, stop}, {28'b0, e_busy, e_start, e_valid, e_stop});
      chk("model_excl", {31'b0, $onehot0({start, valid, stop})}, 32'd1);
      if (e_idx_known) chk("model_index", {16'b0, index}, {16'b0, e_index});
    end
  end

  // Drives one scenario; bit c of each pattern is cycle c after the first request edge.
  task automatic run_seq(input string nm, input int n, input logic [W-1:0] l_main,
                         input logic [W-1:0] l_other, input logic [31:0] req_pat,
                         input logic [31:0] en_pat, input logic [31:0] rst_pat,
                         input logic [31:0] x_start, input logic [31:0] x_valid,
                         input logic [31:0] x_stop, input logic [31:0] x_busy);
    int vi = 0;
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      if (c > 0) begin
        chk({nm, "_start"}, {31'b0, start}, {31'b0, x_start[c]});
        chk({nm, "_valid"}, {31'b0, valid}, {31'b0, x_valid[c]});
        chk({nm, "_stop"},  {31'b0, stop},  {31'b0, x_stop[c]});
        chk({nm, "_busy"},  {31'b0, busy},  {31'b0, x_busy[c]});
        if (x_valid[c]) begin
          chk({nm, "_index"}, {16'b0, index}, vi);
          vi++;
        end
      end
      req = req_pat[c];
      len = (c == 0) ? l_main : l_other;
      en  = en_pat[c];
      rst = rst_pat[c];
    end
    req = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    int beats, last_idx, stop_c;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {28'b0, busy, start, valid, stop}, 32'd0);
    chk("reset_index", {16'b0, index}, 32'd0);
    chk("reset_ctrl4", {28'b0, busy4, start4, valid4, stop4}, 32'd0);
    rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);

    run_seq("basic", 8, 16'd4, 16'd0, 32'b1, 32'hFFFFFFFF, 32'b0,
            32'b10, 32'b111100, 32'b1000000, 32'b1111110);
    run_seq("len0", 4, 16'd0, 16'd0, 32'b1, 32'hFFFFFFFF, 32'b0,
            32'b10, 32'b0, 32'b100, 32'b110);
    run_seq("stall", 9, 16'd3, 16'd0, 32'b1, 32'b110011, 32'b0,
            32'b10, 32'b1100100, 32'b10000000, 32'b11111110);
    run_seq("collide", 4, 16'd2, 16'd9, 32'b10101, 32'hFFFFFFFF, 32'b0,
            32'b10, 32'b1100, 32'b10000, 32'b11110);
    run_seq("after_stop", 8, 16'd5, 16'd0, 32'b1, 32'hFFFFFFFF, 32'b0,
            32'b10, 32'b1111100, 32'b10000000, 32'b11111110);
    run_seq("abort", 8, 16'd8, 16'd0, 32'b1, 32'hFFFFFFFF, 32'b10000,
            32'b10, 32'b11100, 32'b0, 32'b11110);
    run_seq("post_abort", 5, 16'd1, 16'd0, 32'b1, 32'hFFFFFFFF, 32'b0,
            32'b10, 32'b100, 32'b1000, 32'b1110);

    beats = 0; last_idx = -1; stop_c = -1;
    @(negedge clk);
    req4 = 1'b1; len4 = 4'd15; en = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      req4 = 1'b0;
      if (c == 1) chk("max_start", {31'b0, start4}, 32'd1);
      if (valid4) begin beats++; last_idx = int'(index4); end
      if (stop4 && stop_c < 0) stop_c = c;
    end
    chk("max_beats", beats, 32'd15);
    chk("max_last_index", last_idx, 32'd14);
    chk("max_stop_cycle", stop_c, 32'd17);

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst = ($urandom_range(99) == 0);
      req = ($urandom_range(3) == 0);
      len = ($urandom_range(19) == 0) ? W'($urandom_range(40)) : W'($urandom_range(6));
      en  = ($urandom_range(9) < 7);
    end
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
